// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcode encoding and default width.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_ROR  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Signal bundles for the ALU: operand/result bus and the shared clock/reset pair.
interface ALU_if #(
    parameter int WIDTH = alu_pkg::ALU_W
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_sel;
    logic [WIDTH-1:0] ALU_out;
    logic             Carry_out;

    // The requester drives operands and opcode and observes the result.
    modport master (
        output A, B, ALU_sel,
        input  ALU_out, Carry_out
    );

    // The ALU consumes operands and opcode and drives the result.
    modport slave (
        input  A, B, ALU_sel,
        output ALU_out, Carry_out
    );
endinterface

interface clk_if;
    logic clk;
    logic rst;
endinterface

// File: rtl/alu_comb.sv
// Purely combinational compute stage: operands and opcode in, result and carry out.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    logic [WIDTH:0] wide;

    // Decode the opcode; anything unrecognised (including X/Z) falls to zero.
    always_comb begin
        res   = '0;
        carry = 1'b0;
        wide  = '0;
        case (alu_sel)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                res   = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                res   = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            OP_MUL:  res = a * b;
            OP_DIV:  res = (b == '0) ? '1 : a / b;
            OP_SHL:  res = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  res = {1'b0, a[WIDTH-1:1]};
            OP_ROL:  res = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  res = {a[0], a[WIDTH-1:1]};
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_NAND: res = ~(a & b);
            OP_XNOR: res = ~(a ^ b);
            OP_GT:   res = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   res = {{(WIDTH-1){1'b0}}, (a == b)};
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// Registered ALU: combinational compute stage followed by a single output register.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic  clk,
    input  logic  rst,
    ALU_if.slave  bus
);

    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;
    logic             carry_d;
    logic             carry_q;
    logic [WIDTH-1:0] comb_res;
    logic             comb_carry;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a       (bus.A),
        .b       (bus.B),
        .alu_sel (bus.ALU_sel),
        .res     (comb_res),
        .carry   (comb_carry)
    );

    // Next register value is simply this cycle's compute result.
    always_comb begin
        alu_out_d = comb_res;
        carry_d   = comb_carry;
    end

    // Output register; reset clears it immediately so no stale result survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            carry_q   <= carry_d;
        end
    end

    assign bus.ALU_out   = alu_out_q;
    assign bus.Carry_out = carry_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed vectors push expected results, a monitor checks them one clock later.
module tb_alu_core;
   import alu_pkg::*;

   typedef struct {
      logic [7:0] expOut;
      logic       expCarry;
      string      name;
   } expect_t;

   ALU_if #(.WIDTH(8)) aluBus ();
   clk_if clkBus ();

   expect_t expQ[$];
   int      errorCount = 0;
   int      checkCount = 0;
   logic    opInFlight = 1'b0;

   alu_core #(.WIDTH(8)) dut (
      .clk (clkBus.clk),
      .rst (clkBus.rst),
      .bus (aluBus.slave)
   );

   // Free-running clock, 10 time-unit period.
   initial clkBus.clk = 1'b0;
   always #5 clkBus.clk = ~clkBus.clk;

   // Compare one observed result against its expectation and tally the outcome.
   task automatic checkOutput(input string name, input logic [7:0] actOut, input logic actCarry,
                              input logic [7:0] expOut, input logic expCarry);
      checkCount++;
      if (actOut !== expOut || actCarry !== expCarry) begin
         errorCount++;
         $display("[TB] FAIL %s: got out=0x%02h carry=%b, expected out=0x%02h carry=%b",
                  name, actOut, actCarry, expOut, expCarry);
      end
   endtask

   // Drive one operation on the falling edge and queue what should appear after the next rising edge.
   task automatic applyStimulus(input string name, input logic [3:0] sel, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] expOut, input logic expCarry);
      expect_t e;
      @(negedge clkBus.clk);
      aluBus.A       = a;
      aluBus.B       = b;
      aluBus.ALU_sel = sel;
      e.expOut   = expOut;
      e.expCarry = expCarry;
      e.name     = name;
      expQ.push_back(e);
      opInFlight = 1'b1;
   endtask

   // Stop issuing scoreboarded operations.
   task automatic idleStimulus();
      @(negedge clkBus.clk);
      opInFlight = 1'b0;
   endtask

   // Monitor: every rising edge that captured a queued op is checked just after the edge.
   initial begin
      logic   take;
      expect_t e;
      forever begin
         @(posedge clkBus.clk);
         take = opInFlight;
         #1;
         if (take && !clkBus.rst) begin
            if (expQ.size() == 0) begin
               checkCount++;
               errorCount++;
               $display("[TB] FAIL scoreboard: result presented with no expectation queued, out=0x%02h",
                        aluBus.ALU_out);
            end else begin
               e = expQ.pop_front();
               checkOutput(e.name, aluBus.ALU_out, aluBus.Carry_out, e.expOut, e.expCarry);
            end
         end
      end
   end

   initial begin
      int waitCycles;

      // Reset with live operands: output must stay clear for as long as reset is held.
      clkBus.rst     = 1'b1;
      aluBus.A       = 8'h12;
      aluBus.B       = 8'h34;
      aluBus.ALU_sel = OP_ADD;
      #1;
      checkOutput("reset_async", aluBus.ALU_out, aluBus.Carry_out, 8'h00, 1'b0);
      repeat (3) @(posedge clkBus.clk);
      @(negedge clkBus.clk);
      checkOutput("reset_held", aluBus.ALU_out, aluBus.Carry_out, 8'h00, 1'b0);
      clkBus.rst = 1'b0;

      // Back-to-back directed vectors, one per clock.
      applyStimulus("add_0f_01", OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b0);
      applyStimulus("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1);
      applyStimulus("add_80_80", OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1);
      applyStimulus("sub_10_01", OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b0);
      applyStimulus("sub_00_01", OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1);
      applyStimulus("sub_55_55", OP_SUB, 8'h55, 8'h55, 8'h00, 1'b0);
      applyStimulus("sub_00_01b", OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1);
      applyStimulus("mul_10_10", OP_MUL, 8'h10, 8'h10, 8'h00, 1'b0);
      applyStimulus("mul_07_03", OP_MUL, 8'h07, 8'h03, 8'h15, 1'b0);
      applyStimulus("div_64_07", OP_DIV, 8'h64, 8'h07, 8'h0E, 1'b0);
      applyStimulus("div_64_00", OP_DIV, 8'h64, 8'h00, 8'hFF, 1'b0);
      applyStimulus("rol_81", OP_ROL, 8'h81, 8'h00, 8'h03, 1'b0);
      applyStimulus("ror_81", OP_ROR, 8'h81, 8'h00, 8'hC0, 1'b0);
      applyStimulus("shl_81", OP_SHL, 8'h81, 8'h00, 8'h02, 1'b0);
      applyStimulus("shr_81", OP_SHR, 8'h81, 8'h00, 8'h40, 1'b0);
      applyStimulus("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0);
      applyStimulus("or_f0_3c", OP_OR, 8'hF0, 8'h3C, 8'hFC, 1'b0);
      applyStimulus("xor_f0_3c", OP_XOR, 8'hF0, 8'h3C, 8'hCC, 1'b0);
      applyStimulus("nor_f0_3c", OP_NOR, 8'hF0, 8'h3C, 8'h03, 1'b0);
      applyStimulus("nand_f0_3c", OP_NAND, 8'hF0, 8'h3C, 8'hCF, 1'b0);
      applyStimulus("xnor_f0_3c", OP_XNOR, 8'hF0, 8'h3C, 8'h33, 1'b0);
      applyStimulus("gt_05_03", OP_GT, 8'h05, 8'h03, 8'h01, 1'b0);
      applyStimulus("gt_03_05", OP_GT, 8'h03, 8'h05, 8'h00, 1'b0);
      applyStimulus("gt_05_05", OP_GT, 8'h05, 8'h05, 8'h00, 1'b0);
      applyStimulus("eq_05_05", OP_EQ, 8'h05, 8'h05, 8'h01, 1'b0);
      applyStimulus("eq_05_06", OP_EQ, 8'h05, 8'h06, 8'h00, 1'b0);
      idleStimulus();

      // Drain the scoreboard with a bounded wait.
      waitCycles = 0;
      while (expQ.size() != 0 && waitCycles < 20) begin
         @(posedge clkBus.clk);
         waitCycles++;
      end
      checkCount++;
      if (expQ.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL drain: %0d results still pending, expected 0", expQ.size());
      end

      // Reset in the middle of traffic: the held result must clear without a clock edge.
      @(negedge clkBus.clk);
      aluBus.A       = 8'hFF;
      aluBus.B       = 8'h01;
      aluBus.ALU_sel = OP_ADD;
      @(posedge clkBus.clk);
      #2;
      checkOutput("pre_reset_result", aluBus.ALU_out, aluBus.Carry_out, 8'h00, 1'b1);
      aluBus.A = 8'h0F;
      clkBus.rst = 1'b1;
      #1;
      checkOutput("midop_reset_async", aluBus.ALU_out, aluBus.Carry_out, 8'h00, 1'b0);
      @(posedge clkBus.clk);
      #1;
      checkOutput("midop_reset_held", aluBus.ALU_out, aluBus.Carry_out, 8'h00, 1'b0);
      @(negedge clkBus.clk);
      clkBus.rst = 1'b0;

      // First result after release comes from the first sampled edge.
      applyStimulus("post_reset_add", OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b0);
      applyStimulus("post_reset_sub", OP_SUB, 8'h20, 8'h21, 8'hFF, 1'b1);
      idleStimulus();

      waitCycles = 0;
      while (expQ.size() != 0 && waitCycles < 20) begin
         @(posedge clkBus.clk);
         waitCycles++;
      end
      checkCount++;
      if (expQ.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL final_drain: %0d results still pending, expected 0", expQ.size());
      end

      repeat (2) @(posedge clkBus.clk);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
